// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width, writeback source selects,
// load funct3 codes and the MEM/WB pipeline register payload.
package core_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_AW    = 5;
   localparam int unsigned MEM_DEPTH = 1024;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_LOAD = 2'b01;
   localparam logic [1:0] WB_SEL_PC4  = 2'b10;
   localparam logic [1:0] WB_SEL_IMM  = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef struct packed {
      logic              reg_write;
      logic [REG_AW-1:0] rd;
      logic [1:0]        wb_sel;
      logic [2:0]        funct3;
      logic [XLEN-1:0]   alu_result;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   imm;
   } wb_entry_t;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: extracts byte/halfword from an aligned
// memory word and sign- or zero-extends it; word and undefined codes pass through.
module load_formatter
   import core_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      // halfword position ignores offset bit 0
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      result = rdata;
      case (funct3)
         F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// RV32I writeback stage: MEM/WB register, result select, register-file write port
// and retired-instruction counter. Optional WB_BYPASS_EN adds same-cycle read bypass.
module writeback_stage
   import core_pkg::*;
#(
   parameter int unsigned INSTRET_W = 64
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 mem_valid,
   input  logic                 mem_reg_write,
   input  logic [REG_AW-1:0]    mem_rd,
   input  logic [1:0]           mem_wb_sel,
   input  logic [2:0]           mem_funct3,
   input  logic [XLEN-1:0]      mem_alu_result,
   input  logic [XLEN-1:0]      mem_pc,
   input  logic [XLEN-1:0]      mem_imm,
   input  logic [XLEN-1:0]      mem_rdata,
   input  logic                 wb_stall,
   input  logic                 wb_flush,
   output logic [REG_AW-1:0]    addr_rd,
   output logic [XLEN-1:0]      data_rd,
   output logic                 write_enable,
   output logic                 wb_valid,
   output logic [INSTRET_W-1:0] instret
`ifdef WB_BYPASS_EN
   ,
   input  logic [REG_AW-1:0]    byp_rs1,
   input  logic [REG_AW-1:0]    byp_rs2,
   output logic                 byp_rs1_hit,
   output logic                 byp_rs2_hit,
   output logic [XLEN-1:0]      byp_rs1_data,
   output logic [XLEN-1:0]      byp_rs2_data
`endif
);

   wb_entry_t             wb_q;
   logic                  valid_q;
   logic                  written_q;
   logic [INSTRET_W-1:0]  instret_q;
   logic [XLEN-1:0]       load_data;
   logic [XLEN-1:0]       sel_data;
   logic                  retire;

   load_formatter u_load_formatter (
      .rdata  (mem_rdata),
      .offset (wb_q.alu_result[1:0]),
      .funct3 (wb_q.funct3),
      .result (load_data)
   );

   always_comb begin
      sel_data = wb_q.alu_result;
      case (wb_q.wb_sel)
         WB_SEL_LOAD: sel_data = load_data;
         WB_SEL_PC4:  sel_data = wb_q.pc + XLEN'(4);
         WB_SEL_IMM:  sel_data = wb_q.imm;
         default:     sel_data = wb_q.alu_result;
      endcase
   end

   // written_q suppresses a second write while the instruction is held
   always_comb begin
      write_enable = valid_q && wb_q.reg_write && (wb_q.rd != '0) && !written_q;
      addr_rd      = valid_q ? wb_q.rd : '0;
      data_rd      = valid_q ? sel_data : '0;
      wb_valid     = valid_q;
      instret      = instret_q;
      retire       = valid_q && (!wb_stall || wb_flush);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wb_q      <= '0;
         valid_q   <= 1'b0;
         written_q <= 1'b0;
         instret_q <= '0;
      end else begin
         if (retire) begin
            instret_q <= instret_q + INSTRET_W'(1);
         end
         // flush only kills the incoming instruction and wins over stall
         if (wb_flush) begin
            valid_q <= 1'b0;
         end else if (wb_stall) begin
            if (write_enable) begin
               written_q <= 1'b1;
            end
         end else begin
            wb_q.reg_write  <= mem_reg_write;
            wb_q.rd         <= mem_rd;
            wb_q.wb_sel     <= mem_wb_sel;
            wb_q.funct3     <= mem_funct3;
            wb_q.alu_result <= mem_alu_result;
            wb_q.pc         <= mem_pc;
            wb_q.imm        <= mem_imm;
            valid_q         <= mem_valid;
            written_q       <= 1'b0;
         end
      end
   end

`ifdef WB_BYPASS_EN
   // write-through for decode reads of a register not yet committed
   always_comb begin
      byp_rs1_hit  = write_enable && (byp_rs1 == addr_rd);
      byp_rs2_hit  = write_enable && (byp_rs2 == addr_rd);
      byp_rs1_data = byp_rs1_hit ? data_rd : '0;
      byp_rs2_data = byp_rs2_hit ? data_rd : '0;
   end
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the RV32I core: holds the MEM/WB pipeline register and produces the register-file write port (rd address, rd data, write enable).
- Selects the result source: ALU, load, PC+4 or immediate. Formats load data (byte/half extract, sign/zero extend).
- Counts retired instructions.
- Sits between the data-memory stage and the register file write port; the register file commits on the following posedge.

Parameters:
- XLEN, 32, datapath width
- INSTRET_W, 64, width of retired-instruction counter

Ports:
- clock  in  1  core clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- mem_valid  in  1  MEM stage presents an instruction this cycle
- mem_reg_write  in  1  instruction writes rd
- mem_rd  in  5  destination register
- mem_wb_sel  in  2  00 ALU, 01 LOAD, 10 PC+4, 11 IMM
- mem_funct3  in  3  load size/sign code
- mem_alu_result  in  XLEN  ALU result; also the load byte address
- mem_pc  in  XLEN  instruction PC
- mem_imm  in  XLEN  U-type immediate
- mem_rdata  in  XLEN  aligned memory word; valid during the WB cycle (synchronous-read memory)
- wb_stall  in  1  hold the WB register
- wb_flush  in  1  kill the instruction entering WB
- addr_rd  out  5  to register file
- data_rd  out  XLEN  to register file
- write_enable  out  1  to register file
- wb_valid  out  1  WB holds a live instruction
- instret  out  INSTRET_W  retired count

Behaviour:
- Reset (asynchronous, active-high):
  - wb_valid, write_enable, addr_rd, data_rd, instret and the internal "written" flag all go to 0 immediately.
  - An in-flight write is dropped and never committed.
- Posedge update, no reset:
  - wb_flush=1: valid register <= 0. Flush overrides stall.
  - Else wb_stall=1: WB register holds.
  - Else: WB register <= mem_* fields; valid <= mem_valid; written <= 0.
- write_enable (combinational from the WB register) = valid AND reg_write AND (rd != 0) AND NOT written.
- written is set at a posedge where write_enable=1 and the register holds. Effect: a stalled instruction writes exactly once.
- addr_rd = WB rd whenever valid, else 0.
- data_rd = selected result when valid, else 0:
  - ALU: alu_result.
  - PC+4: pc + 4, modulo 2^32.
  - IMM: imm.
  - LOAD: formatted from mem_rdata using off = alu_result[1:0]:
    - LB/LBU (000/100): byte at off, sign- or zero-extended.
    - LH/LHU (001/101): halfword at alu_result[1] (bit 0 ignored), sign- or zero-extended.
    - LW (010), and undefined codes 011/110/111: full word.
- Latency: the instruction is captured at posedge N, data_rd and write_enable are driven during cycle N, and the register file commits at N+1.
- instret:
  - Increments by 1 at each posedge where valid=1 and the instruction leaves WB (wb_stall=0 or wb_flush=1). This counts rd=0 and non-writing instructions.
  - A held instruction counts once.
  - Wraps at 2^INSTRET_W.
- Flushing the instruction currently in WB is not possible. A flush only kills the instruction entering.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - Adds inputs byp_rs1, byp_rs2 (5 each).
  - Adds outputs byp_rs1_hit, byp_rs2_hit (1) and byp_rs1_data, byp_rs2_data (XLEN).
  - hit = write_enable AND (byp_rsN == addr_rd); data = data_rd when hit, else 0.
  - This gives same-cycle write-through to decode-stage reads, because register-file reads do not see an uncommitted write.
- Undefined: these ports are absent. The hazard unit must stall one extra cycle on a WB-to-decode dependency.

Decomposition:
- Shared package core_pkg:
  - XLEN.
  - WB_SEL_ALU/LOAD/PC4/IMM constants.
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - MEM_DEPTH.
- One sub-module load_formatter: combinational rdata/offset/funct3 -> XLEN result. It is reusable by any future load-reserved path.

Test Plan:
- Reset mid-write: mem_valid=1, rd=5, ALU=0x1234, capture, assert reset in the same cycle -> write_enable=0, data_rd=0, instret=0 immediately; x5 unchanged.
- Load formatting: mem_rdata=0x80FF7F01, alu_result=0x...01, LB -> data_rd=0x0000007F. Offset 3, LB -> 0xFFFFFF80. LHU at addr bit 1=1 -> 0x000080FF. LW -> 0x80FF7F01.
- Stall: ALU op rd=7 held 3 cycles by wb_stall -> write_enable high exactly 1 cycle; instret +1 only after stall releases.
- rd=0 and flush: reg_write with rd=0 -> write_enable=0, instret +1. wb_flush together with wb_stall -> wb_valid=0 next cycle, no write.
- PC+4 wrap: pc=0xFFFFFFFC, sel=10 -> data_rd=0x00000000. IMM sel with imm=0xABCDE000 -> data_rd=0xABCDE000.
- With WB_BYPASS_EN: byp_rs1=9 while WB writes x9=0x55 -> byp_rs1_hit=1, data 0x55. byp_rs2=0 -> hit=0.
